// File: rtl/acc_cpu_controller.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Owns PC/IR/AR/DR/ACC, drives the external ALU and a synchronous-read 256x8 memory.
module acc_cpu_controller #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [3:0] ALU_IDLE = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  output logic [7:0] acc,
  output logic [7:0] pc,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_LOADIR, S_DECODE, S_LOADAR, S_OPREAD,
    S_OPLOAD, S_STORE, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_CLA = 4'h1;
  localparam logic [3:0] OP_COM = 4'h2;
  localparam logic [3:0] OP_SHR = 4'h3;
  localparam logic [3:0] OP_CSL = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_STA = 4'h6;
  localparam logic [3:0] OP_LDA = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  // Only the opcode nibble of the instruction byte is kept; ir[3:0] is never used.
  logic [3:0] ir_q, ir_d;
  logic [7:0] ar_q, ar_d;
  logic [7:0] dr_q, dr_d;
  logic [7:0] acc_q, acc_d;
  logic       illegal_q, illegal_d;
  logic       rd_c, wr_c;

  // NOTE: state uses non-blocking assignments only; the comb block computes every _d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      ar_q      <= '0;
      dr_q      <= '0;
      acc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ar_q      <= ar_d;
      dr_q      <= dr_d;
      acc_q     <= acc_d;
      illegal_q <= illegal_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ar_d      = ar_q;
    dr_d      = dr_q;
    acc_d     = acc_q;
    illegal_d = illegal_q;
    mem_addr  = pc_q;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    alu_op    = ALU_IDLE;

    case (state_q)
      S_FETCH: begin
        if (run) begin
          rd_c    = 1'b1;
          state_d = S_LOADIR;
        end
      end
      S_LOADIR: begin
        ir_d    = mem_rdata[7:4];
        pc_d    = pc_q + 8'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_q)
          OP_CLA, OP_COM, OP_SHR, OP_CSL: state_d = S_EXEC;
          OP_HLT:                         state_d = S_HALT;
          OP_ADD, OP_STA, OP_LDA, OP_JMP, OP_JZ: begin
            rd_c    = 1'b1;
            state_d = S_LOADAR;
          end
          OP_NOP:                         state_d = S_FETCH;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_LOADAR: begin
        ar_d = mem_rdata;
        pc_d = pc_q + 8'd1;
        case (ir_q)
          OP_JMP: begin
            pc_d    = mem_rdata;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (acc_q == 8'h00) pc_d = mem_rdata;
            state_d = S_FETCH;
          end
          OP_STA:  state_d = S_STORE;
          default: state_d = S_OPREAD;
        endcase
      end
      S_OPREAD: begin
        mem_addr = ar_q;
        rd_c     = 1'b1;
        state_d  = S_OPLOAD;
      end
      S_OPLOAD: begin
        dr_d    = mem_rdata;
        state_d = S_EXEC;
      end
      S_STORE: begin
        mem_addr = ar_q;
        wr_c     = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC: begin
        alu_op  = ir_q;
        acc_d   = alu_result;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked by rst so a pending write drops without waiting for an edge.
  assign mem_rd    = rd_c & ~rst;
  assign mem_wr    = wr_c & ~rst;
  assign mem_wdata = acc_q;
  assign alu_a     = acc_q;
  assign alu_b     = dr_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_acc_cpu_controller.sv
// Directed bench for acc_cpu_controller with a behavioural 256x8 sync-read memory and 8-bit ALU.
module tb_acc_cpu_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b1;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;
  logic       mem_rd, mem_wr;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [7:0] acc, pc;
  logic       halted, illegal;

  logic [7:0] mem [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  acc_cpu_controller #(.RESET_PC(8'h00), .ALU_IDLE(4'h0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .acc(acc), .pc(pc), .halted(halted), .illegal(illegal)
  );

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  // Reference ALU: 1 CLA, 2 COM, 3 SHR, 4 CSL (rotate left), 5 ADD, 7 LDA.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      4'h1: alu_result = 8'h00;
      4'h2: alu_result = ~alu_a;
      4'h3: alu_result = alu_a >> 1;
      4'h4: alu_result = {alu_a[6:0], alu_a[7]};
      4'h5: alu_result = alu_a + alu_b;
      4'h7: alu_result = alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic enter_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, halted, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, strobes masked while run is high.
    clear_mem();
    #2;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_pc", pc, 8'h00);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);

    // LDA 10 / ADD 11 / HLT
    mem[0] = 8'h70; mem[1] = 8'h10; mem[2] = 8'h50; mem[3] = 8'h11; mem[4] = 8'hF0;
    mem[8'h10] = 8'h25; mem[8'h11] = 8'h1E;
    release_rst();
    step(6);  check("lda_acc_c6", acc, 8'h00);
    step(1);  check("lda_acc_c7", acc, 8'h25);
    step(6);  check("add_acc_c13", acc, 8'h25);
    step(1);  check("add_acc_c14", acc, 8'h43);
    step(2);  check("hlt_not_yet", halted, 0);
    step(1);  check("hlt_halted", halted, 1);
    check("hlt_pc", pc, 8'h05);
    step(2);  check("hlt_alu_idle", alu_op, 0);
    check("hlt_no_rd", mem_rd, 0);

    // Repeated COM: op returns to idle between the two EXEC cycles.
    enter_rst();
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h20; mem[2] = 8'hF0;
    release_rst();
    step(2);  check("com_op_c2", alu_op, 0);
    step(1);  check("com_op_c3", alu_op, 2);
    check("com_a_c3", alu_a, 8'h00);
    step(1);  check("com_op_c4", alu_op, 0);
    check("com_acc_c4", acc, 8'hFF);
    step(2);  check("com_op_c6", alu_op, 0);
    step(1);  check("com_op_c7", alu_op, 2);
    step(1);  check("com_op_c8", alu_op, 0);
    check("com_acc_c8", acc, 8'h00);

    // CLA / STA 20 / JZ 07 taken / HLT at 07
    enter_rst();
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h60; mem[2] = 8'h20; mem[3] = 8'h90; mem[4] = 8'h07;
    mem[7] = 8'hF0; mem[8'h20] = 8'hAA;
    release_rst();
    step(4);  check("sta_acc", acc, 8'h00);
    step(3);  check("sta_wr_c7", mem_wr, 0);
    step(1);  check("sta_wr_c8", mem_wr, 1);
    check("sta_addr", mem_addr, 8'h20);
    check("sta_wdata", mem_wdata, 8'h00);
    check("sta_rd_c8", mem_rd, 0);
    step(1);  check("sta_wr_c9", mem_wr, 0);
    check("sta_mem20", mem[8'h20], 8'h00);
    step(4);  check("jz_taken_pc", pc, 8'h07);
    wait_halt("jz_taken_halt", 20);
    check("jz_taken_halt_pc", pc, 8'h08);

    // Same with COM inserted: JZ falls through.
    enter_rst();
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h60; mem[2] = 8'h20; mem[3] = 8'h20; mem[4] = 8'h90;
    mem[5] = 8'h07; mem[6] = 8'hF0; mem[7] = 8'hF0; mem[8'h20] = 8'hAA;
    release_rst();
    step(13); check("jznt_acc", acc, 8'hFF);
    check("jznt_mem20", mem[8'h20], 8'h00);
    step(4);  check("jznt_pc", pc, 8'h06);
    wait_halt("jznt_halt", 20);
    check("jznt_halt_pc", pc, 8'h07);

    // PC wrap on the address byte: JMP FE, then JMP 05 straddling FF->00.
    enter_rst();
    clear_mem();
    mem[0] = 8'h80; mem[1] = 8'hFE; mem[8'hFE] = 8'h80; mem[8'hFF] = 8'h05; mem[5] = 8'hF0;
    release_rst();
    step(4);  check("wrap_jmp1_pc", pc, 8'hFE);
    step(2);  check("wrap_ir_pc", pc, 8'hFF);
    step(2);  check("wrap_jmp2_pc", pc, 8'h05);
    wait_halt("wrap_halt", 20);
    check("wrap_halt_pc", pc, 8'h06);

    // NOP at FF wraps PC to 00.
    enter_rst();
    clear_mem();
    mem[0] = 8'h80; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    release_rst();
    step(4);  check("nopwrap_pc_ff", pc, 8'hFF);
    step(2);  check("nopwrap_pc_00", pc, 8'h00);

    // Illegal opcode: sticky flag, acc kept, 3-cycle timing.
    enter_rst();
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'hB0; mem[2] = 8'hF0;
    release_rst();
    step(6);  check("ill_c6", illegal, 0);
    step(1);  check("ill_c7", illegal, 1);
    step(2);  check("ill_halt_c9", halted, 0);
    step(1);  check("ill_halt_c10", halted, 1);
    check("ill_acc", acc, 8'hFF);
    check("ill_sticky", illegal, 1);
    enter_rst();
    check("ill_cleared", illegal, 0);

    // Reset during STORE, then hold run low.
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h60; mem[2] = 8'h20; mem[3] = 8'hF0; mem[8'h20] = 8'hAA;
    release_rst();
    step(4);  check("rsta_acc", acc, 8'hFF);
    step(4);  check("rsta_wr_hi", mem_wr, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rsta_wr_async", mem_wr, 0);
    check("rsta_pc", pc, 8'h00);
    check("rsta_acc0", acc, 8'h00);
    run = 1'b0;
    release_rst();
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("run0_rd", mem_rd, 0);
      check("run0_pc", pc, 8'h00);
    end
    check("rsta_mem20", mem[8'h20], 8'hAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
